// File: rtl/div_result_ctrl.sv
// Sequencing controller around a combinational signed divider: latches operands,
// waits SETTLE cycles for the divider path, then holds the HI/LO result until acknowledged.
module div_result_ctrl #(
    parameter int SETTLE = 4
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic signed [31:0] dividend,
    input  logic signed [31:0] divisor,
    input  logic               flush,
    input  logic               done_ack,
    output logic signed [31:0] div_a,
    output logic signed [31:0] div_b,
    input  logic        [63:0] div_z,
    output logic signed [31:0] hi,
    output logic signed [31:0] lo,
    output logic               busy,
    output logic               done,
    output logic               dbz
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt;
    logic       accept;
    logic       take_dbz;
    logic       capture;
    logic       count_down;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= IDLE;
        else      state <= state_nxt;
    end

    // flush wins over both counter expiry and done_ack; a start coinciding with flush is dropped
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        take_dbz   = 1'b0;
        capture    = 1'b0;
        count_down = 1'b0;
        case (state)
            IDLE: begin
                if (start && !flush) begin
                    if (divisor != 32'sd0) begin
                        accept    = 1'b1;
                        state_nxt = WAIT;
                    end else begin
                        take_dbz  = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            WAIT: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (cnt == 4'd0) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    count_down = 1'b1;
                end
            end
            DONE: begin
                if (flush || done_ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latches, settle counter and result registers
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt   <= 4'd0;
            div_a <= '0;
            div_b <= '0;
            hi    <= '0;
            lo    <= '0;
            dbz   <= 1'b0;
        end else begin
            if (accept) begin
                div_a <= dividend;
                div_b <= divisor;
                cnt   <= 4'(SETTLE - 1);
                dbz   <= 1'b0;
            end
            if (count_down) cnt <= cnt - 4'd1;
            if (take_dbz) begin
                hi  <= dividend;
                lo  <= 32'hFFFF_FFFF;
                dbz <= 1'b1;
            end
            if (capture) begin
                hi <= div_z[63:32];
                lo <= div_z[31:0];
            end
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_div_result_ctrl.sv
// Directed bench for div_result_ctrl with a behavioural signed divider on div_a/div_b.
module tb_div_result_ctrl;

    logic               clk;
    logic               clr;
    logic               start;
    logic signed [31:0] dividend;
    logic signed [31:0] divisor;
    logic               flush;
    logic               done_ack;
    logic signed [31:0] div_a;
    logic signed [31:0] div_b;
    logic        [63:0] div_z;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    logic               busy;
    logic               done;
    logic               dbz;

    int checks = 0;
    int errors = 0;

    div_result_ctrl #(.SETTLE(4)) dut (
        .clk(clk), .clr(clr), .start(start), .dividend(dividend), .divisor(divisor),
        .flush(flush), .done_ack(done_ack), .div_a(div_a), .div_b(div_b), .div_z(div_z),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .dbz(dbz)
    );

    // External divider: truncating signed divide, remainder follows dividend sign
    always_comb begin
        if (div_b == 32'sd0) div_z = 64'd0;
        else                 div_z = {32'(div_a % div_b), 32'(div_a / div_b)};
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic issue(input logic signed [31:0] a, input logic signed [31:0] b);
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic ack();
        done_ack = 1'b1;
        @(negedge clk);
        done_ack = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b0;
        #3;
        checks++; if ({busy, done, dbz} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b required 000", {busy, done, dbz}); end
        repeat (2) @(negedge clk);
        checks++; if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL reset_hilo: got %h required 0", {hi, lo}); end
        checks++; if ({div_a, div_b} !== 64'd0) begin errors++; $display("FAIL reset_operands: got %h required 0", {div_a, div_b}); end
        clr = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        issue(100, 7);
        wait_done(lat);
        checks++; if (lat != 5) begin errors++; $display("FAIL basic_latency: got %0d required 5", lat); end
        checks++; if (hi !== 32'sd2 || lo !== 32'sd14) begin errors++; $display("FAIL basic_result: got hi=%0d lo=%0d required hi=2 lo=14", hi, lo); end
        checks++; if (dbz !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL basic_flags: got dbz=%b busy=%b required 0 1", dbz, busy); end
        checks++; if (div_a !== 32'sd100 || div_b !== 32'sd7) begin errors++; $display("FAIL basic_operands: got %0d/%0d required 100/7", div_a, div_b); end
        repeat (3) @(negedge clk);
        checks++; if (done !== 1'b1 || hi !== 32'sd2 || lo !== 32'sd14) begin errors++; $display("FAIL basic_hold: got done=%b hi=%0d lo=%0d required 1 2 14", done, hi, lo); end
        ack();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_ack: got done=%b busy=%b required 0 0", done, busy); end
        checks++; if (hi !== 32'sd2 || lo !== 32'sd14) begin errors++; $display("FAIL basic_retain: got hi=%0d lo=%0d required 2 14", hi, lo); end
    endtask

    task automatic test_negative();
        int lat;
        issue(-7, 2);
        wait_done(lat);
        checks++; if (lat != 5) begin errors++; $display("FAIL neg_latency: got %0d required 5", lat); end
        checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL neg_result: got hi=%h lo=%h required ffffffff fffffffd", hi, lo); end
        ack();
    endtask

    task automatic test_div_by_zero();
        int lat;
        issue(5, 0);
        wait_done(lat);
        checks++; if (lat != 1) begin errors++; $display("FAIL dbz_latency: got %0d required 1", lat); end
        checks++; if (dbz !== 1'b1 || hi !== 32'sd5 || lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dbz_result: got dbz=%b hi=%h lo=%h required 1 5 ffffffff", dbz, hi, lo); end
        checks++; if (div_a !== -32'sd7 || div_b !== 32'sd2) begin errors++; $display("FAIL dbz_operands: got %0d/%0d required -7/2", div_a, div_b); end
        ack();
        checks++; if (dbz !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL dbz_retain: got dbz=%b busy=%b required 1 0", dbz, busy); end
        issue(9, 3);
        checks++; if (dbz !== 1'b0) begin errors++; $display("FAIL dbz_clear: got %b required 0", dbz); end
        wait_done(lat);
        checks++; if (lat != 5 || hi !== 32'sd0 || lo !== 32'sd3) begin errors++; $display("FAIL after_dbz: got lat=%0d hi=%0d lo=%0d required 5 0 3", lat, hi, lo); end
        ack();
    endtask

    task automatic test_start_ignored();
        int lat;
        issue(77, 8);
        @(negedge clk);
        start = 1'b1; dividend = 50; divisor = 5;
        @(negedge clk);
        start = 1'b0;
        checks++; if (div_a !== 32'sd77 || div_b !== 32'sd8) begin errors++; $display("FAIL wait_start_operands: got %0d/%0d required 77/8", div_a, div_b); end
        wait_done(lat);
        checks++; if (lat < 0 || hi !== 32'sd5 || lo !== 32'sd9) begin errors++; $display("FAIL wait_start_result: got lat=%0d hi=%0d lo=%0d required hi=5 lo=9", lat, hi, lo); end
        done_ack = 1'b1; start = 1'b1; dividend = 50; divisor = 5;
        @(negedge clk);
        done_ack = 1'b0; start = 1'b0;
        checks++; if (busy !== 1'b0 || div_a !== 32'sd77) begin errors++; $display("FAIL ack_start: got busy=%b div_a=%0d required 0 77", busy, div_a); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ack_start_queue: got busy=%b required 0", busy); end
    endtask

    task automatic test_flush();
        int lat;
        int seen;
        issue(20, 3);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_wait: got busy=%b required 0", busy); end
        seen = 0;
        repeat (8) begin @(negedge clk); if (done !== 1'b0) seen++; end
        checks++; if (seen != 0) begin errors++; $display("FAIL flush_no_done: got %0d done cycles required 0", seen); end
        checks++; if (hi !== 32'sd5 || lo !== 32'sd9) begin errors++; $display("FAIL flush_retain: got hi=%0d lo=%0d required 5 9", hi, lo); end
        issue(9, 2);
        wait_done(lat);
        flush = 1'b1; done_ack = 1'b1;
        @(negedge clk);
        flush = 1'b0; done_ack = 1'b0;
        checks++; if (busy !== 1'b0 || hi !== 32'sd1 || lo !== 32'sd4) begin errors++; $display("FAIL flush_done: got busy=%b hi=%0d lo=%0d required 0 1 4", busy, hi, lo); end
        flush = 1'b1; start = 1'b1; dividend = 30; divisor = 6;
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        checks++; if (busy !== 1'b0 || div_a !== 32'sd9) begin errors++; $display("FAIL flush_idle_start: got busy=%b div_a=%0d required 0 9", busy, div_a); end
    endtask

    task automatic test_clr_midop();
        int lat;
        int seen;
        issue(100, 7);
        repeat (2) @(negedge clk);
        #2 clr = 1'b0;
        #1;
        checks++; if ({busy, done, dbz} !== 3'b000 || {hi, lo} !== 64'd0 || {div_a, div_b} !== 64'd0) begin errors++; $display("FAIL clr_async: got flags=%b hilo=%h ab=%h required all 0", {busy, done, dbz}, {hi, lo}, {div_a, div_b}); end
        @(negedge clk);
        clr = 1'b1;
        seen = 0;
        repeat (8) begin @(negedge clk); if (done !== 1'b0 || busy !== 1'b0) seen++; end
        checks++; if (seen != 0) begin errors++; $display("FAIL clr_no_done: got %0d active cycles required 0", seen); end
        clr = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        issue(9, 3);
        wait_done(lat);
        checks++; if (lat != 5 || hi !== 32'sd0 || lo !== 32'sd3 || dbz !== 1'b0) begin errors++; $display("FAIL clr_restart: got lat=%0d hi=%0d lo=%0d dbz=%b required 5 0 3 0", lat, hi, lo, dbz); end
        ack();
    endtask

    initial begin
        start = 1'b0; dividend = '0; divisor = '0; flush = 1'b0; done_ack = 1'b0;
        test_reset();
        test_basic();
        test_negative();
        test_div_by_zero();
        test_start_ignored();
        test_flush();
        test_clr_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_result_ctrl.md
DIV_RESULT_CTRL -- requirements
Module: div_result_ctrl

Interface
REQ-001 Parameter SETTLE, default 4, sets the cycles allowed for the combinational divider path to settle; legal range 1..15.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 clr  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  request a divide; sampled only in IDLE.
REQ-005 dividend  in  32  signed dividend operand.
REQ-006 divisor  in  32  signed divisor operand.
REQ-007 flush  in  1  synchronous abort of an operation in flight.
REQ-008 done_ack  in  1  consumer accepts the result.
REQ-009 div_a  out  32  latched dividend, driven to the divider.
REQ-010 div_b  out  32  latched divisor, driven to the divider.
REQ-011 div_z  in  64  divider result: {remainder[63:32], quotient[31:0]}.
REQ-012 hi  out  32  registered remainder (HI).
REQ-013 lo  out  32  registered quotient (LO).
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 done  out  1  high only in DONE; the result is valid.
REQ-016 dbz  out  1  divide-by-zero flag for the current or last result.

Function
REQ-017 The FSM SHALL have the states IDLE, WAIT and DONE, and all outputs SHALL be registered or decoded from state only.
REQ-018 In IDLE, when start=1 and divisor!=0, the block SHALL latch dividend into div_a and divisor into div_b, load the counter with SETTLE-1, clear dbz, and enter WAIT.
REQ-019 In IDLE, when start=1 and divisor==0, the block SHALL set hi=dividend, lo=32'hFFFFFFFF and dbz=1, and enter DONE on the next edge without using div_z.
REQ-020 In WAIT, when the counter is nonzero, the block SHALL decrement the counter.
REQ-021 In WAIT, when the counter is 0, the block SHALL capture hi=div_z[63:32] and lo=div_z[31:0] and enter DONE.
REQ-022 Latency from the start edge to the first done=1 cycle SHALL be exactly SETTLE+1 cycles, or 1 cycle for a divide by zero.
REQ-023 In DONE, done SHALL hold high and hi/lo SHALL hold until done_ack=1 is sampled, after which the block SHALL return to IDLE.
REQ-024 start SHALL be ignored in WAIT and DONE, with no queueing; start in the same cycle as done_ack in DONE SHALL be ignored.
REQ-025 flush=1 in WAIT or DONE SHALL return the block to IDLE on the next edge without updating hi, lo or dbz.
REQ-026 flush SHALL take precedence over done_ack and over counter expiry.
REQ-027 flush in IDLE SHALL have no effect, and start SHALL not be accepted in the same cycle as flush.
REQ-028 div_a and div_b SHALL change only on an accepted start.
REQ-029 hi, lo and dbz SHALL retain their last result in IDLE.
REQ-030 Quotient and remainder semantics SHALL be those of the divider: truncation toward zero, with the remainder taking the sign of the dividend.

Reset
REQ-031 clr=0 SHALL immediately force state=IDLE, counter=0, div_a=0, div_b=0, hi=0, lo=0, dbz=0, busy=0 and done=0, independent of clk.
REQ-032 Reset asserted mid-operation SHALL discard the operation, and no done SHALL follow the release of reset.
REQ-033 After clr is released, the first start SHALL be accepted on the first rising edge.

Verification
REQ-034 With SETTLE=4, start with 100/7 -> done rises 5 cycles after the start edge, hi=2, lo=14, dbz=0; done holds until done_ack.
REQ-035 Start with -7/2 -> hi=32'hFFFFFFFF (-1), lo=32'hFFFFFFFD (-3).
REQ-036 Start with 5/0 -> done rises the next cycle, dbz=1, hi=5, lo=32'hFFFFFFFF; a following 9/3 -> dbz=0, hi=0, lo=3.
REQ-037 A second start with 50/5 pulsed during WAIT -> ignored; div_a and div_b unchanged; the first result is returned.
REQ-038 flush during WAIT of 20/3 -> IDLE next edge, hi and lo keep the prior result, no done pulse occurs.
REQ-039 clr pulsed low during WAIT -> all outputs 0 asynchronously, no done afterwards, and a new start after release completes normally.
